// File: rtl/ad9783_pkg.sv
// ad9783_pkg: register map, sequencer states and frame builder for the AD9783 SPI configuration
package ad9783_pkg;
  localparam logic [4:0] ADDR_MODE   = 5'h0A;
  localparam logic [4:0] ADDR_FSC1_L = 5'h0B;
  localparam logic [4:0] ADDR_FSC1_H = 5'h0C;
  localparam logic [4:0] ADDR_FSC2_L = 5'h0F;
  localparam logic [4:0] ADDR_FSC2_H = 5'h10;
  localparam logic [2:0] NUM_FRAMES  = 3'd5;
  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, LOAD, SHIFT, GAP, IDLE} state_t;
  typedef struct packed {
    logic [1:0] dac2_mode;
    logic [9:0] dac2_fsc;
    logic [1:0] dac1_mode;
    logic [9:0] dac1_fsc;
  } cfg_t;
  // Instruction byte is {R/W=0, N=00, addr}; the data byte follows.
  function automatic logic [15:0] frame_word(input logic [2:0] idx, input cfg_t c);
    logic [4:0] addr;
    logic [7:0] data;
    addr = idx == 3'd0 ? ADDR_MODE : idx == 3'd1 ? ADDR_FSC1_L : idx == 3'd2 ? ADDR_FSC1_H :
           idx == 3'd3 ? ADDR_FSC2_L : ADDR_FSC2_H;
    data = idx == 3'd0 ? {4'b0, c.dac2_mode, c.dac1_mode} : idx == 3'd1 ? c.dac1_fsc[7:0] :
           idx == 3'd2 ? {6'b0, c.dac1_fsc[9:8]} : idx == 3'd3 ? c.dac2_fsc[7:0] :
           {6'b0, c.dac2_fsc[9:8]};
    return {3'b000, addr, data};
  endfunction
endpackage

// File: rtl/ad9783_spi_cfg_tx16.sv
// spi_tx16: shifts one 16-bit 3-wire SPI write frame MSB first; SCLK idles low, data changes on falling edges
module spi_tx16 #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data,
  output logic        done,
  output logic        csb,
  output logic        sclk,
  output logic        sdo,
  output logic        sdo_oe
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  logic [7:0]  div;
  logic [3:0]  nfall;
  logic [14:0] sh;
  logic        tick;
  assign tick = !csb && div == DIV_LAST;
  // done is combinational so the sequencer leaves SHIFT on the same edge csb rises
  assign done = tick && sclk && nfall == 4'd15;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      csb    <= 1'b1;
      sclk   <= 1'b0;
      sdo    <= 1'b0;
      sdo_oe <= 1'b0;
      div    <= '0;
      nfall  <= '0;
      sh     <= '0;
    end else if (start) begin
      csb    <= 1'b0;
      sdo_oe <= 1'b1;
      sdo    <= data[15];
      sh     <= data[14:0];
      sclk   <= 1'b0;
      div    <= '0;
      nfall  <= '0;
    end else if (!csb) begin
      div <= tick ? 8'd0 : div + 8'd1;
      if (tick) sclk <= !sclk;
      if (done) begin
        csb    <= 1'b1;
        sdo_oe <= 1'b0;
        sdo    <= 1'b0;
      end else if (tick && sclk) begin
        sdo   <= sh[14];
        sh    <= {sh[13:0], 1'b0};
        nfall <= nfall + 4'd1;
      end
    end
endmodule

// File: rtl/ad9783_spi_cfg.sv
// ad9783_spi_cfg: pulses the AD9783 reset, writes its 5 config registers over SPI, and rewrites on any change
import ad9783_pkg::*;
module ad9783_spi_cfg #(
  parameter int CLK_DIV  = 2,
  parameter int RST_CYC  = 50,
  parameter int WAIT_CYC = 100,
  parameter int CS_GAP   = 4
) (
  input  logic       clk_5m_bufg,
  input  logic       rst_glb_n,
  input  logic [9:0] dac1_fsc,
  input  logic [1:0] dac1_mode,
  input  logic [9:0] dac2_fsc,
  input  logic [1:0] dac2_mode,
  output logic       spi_csb,
  output logic       spi_clk,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic       spi_rst,
  output logic       cfg_busy,
  output logic       cfg_done
);
  localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
  state_t      state, nxt;
  logic [15:0] cnt;
  logic [2:0]  idx;
  cfg_t        live, snap;
  logic        tx_done;
  assign live = {dac2_mode, dac2_fsc, dac1_mode, dac1_fsc};
  always_comb begin
    nxt = state;
    case (state)
      RST_HOLD: nxt = cnt == RST_LAST ? RST_WAIT : RST_HOLD;
      RST_WAIT: nxt = cnt == WAIT_LAST ? LOAD : RST_WAIT;
      LOAD:     nxt = SHIFT;
      SHIFT:    nxt = tx_done ? GAP : SHIFT;
      GAP:      nxt = cnt != GAP_LAST ? GAP : idx == NUM_FRAMES - 3'd1 ? IDLE : LOAD;
      IDLE:     nxt = live != snap ? LOAD : IDLE;
      default:  nxt = RST_HOLD;
    endcase
  end
  // A sequence start is any entry to LOAD not coming from GAP; only then is the snapshot taken.
  always_ff @(posedge clk_5m_bufg or negedge rst_glb_n)
    if (!rst_glb_n) begin
      state    <= RST_HOLD;
      cnt      <= '0;
      idx      <= '0;
      snap     <= '0;
      spi_rst  <= 1'b1;
      cfg_busy <= 1'b1;
      cfg_done <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? 16'd0 : cnt + 16'd1;
      if (nxt == LOAD && state != GAP) begin
        snap <= live;
        idx  <= '0;
      end else if (nxt == LOAD) idx <= idx + 3'd1;
      spi_rst  <= nxt == RST_HOLD;
      cfg_busy <= nxt != IDLE;
      cfg_done <= state == IDLE && live == snap;
    end
  spi_tx16 #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk    (clk_5m_bufg),
    .rst_n  (rst_glb_n),
    .start  (state == LOAD),
    .data   (frame_word(idx, snap)),
    .done   (tx_done),
    .csb    (spi_csb),
    .sclk   (spi_clk),
    .sdo    (spi_sdo),
    .sdo_oe (spi_sdo_oe)
  );
endmodule
